// File: rtl/cpu_defs.sv
// Shared CPU definitions used by the multiply/divide unit: op encodings,
// FSM state encoding and default datapath width.
package cpu_defs;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Conditional two's-complement negation: gives |x| at operand entry and
// re-applies the sign to magnitude results.
module md_sign_fix #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]        i_mag,
    input  logic                     i_neg,
    output logic signed [DATA_W-1:0] o_res
);

    always_comb begin
        o_res = i_neg ? $signed(-i_mag) : $signed(i_mag);
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding HI/LO: magnitude shift-add multiply
// and restoring divide, one bit per cycle, with a final sign-fix cycle.
module muldiv_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          r_state;
    md_state_e          w_state_nxt;
    logic               r_done;
    md_op_e             r_op;
    logic               r_sa;
    logic               r_sb;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    md_op_e             w_op_in;
    logic               w_sa_in;
    logic               w_sb_in;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_is_div;
    logic               w_last;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_msum;

    logic [WIDTH:0]     w_dshift;
    logic               w_dfit;
    logic [WIDTH-1:0]   w_ddiff;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_dvd;
    logic               w_dz;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // Operand entry: strip signs of signed ops so the iteration is unsigned.
    assign w_op_in = md_op_e'(op);
    assign w_sa_in = md_is_signed(w_op_in) & rs_data[WIDTH-1];
    assign w_sb_in = md_is_signed(w_op_in) & rt_data[WIDTH-1];

    md_sign_fix #(.DATA_W(WIDTH)) u_abs_a (
        .i_mag (rs_data),
        .i_neg (w_sa_in),
        .o_res (w_abs_a)
    );

    md_sign_fix #(.DATA_W(WIDTH)) u_abs_b (
        .i_mag (rt_data),
        .i_neg (w_sb_in),
        .o_res (w_abs_b)
    );

    assign w_is_div = md_is_div(r_op);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Multiply step: add multiplicand into the high half, shift whole accumulator right.
    assign w_addend = r_b[0] ? r_a : '0;
    assign w_msum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    // Restoring divide step: remainder always fits WIDTH bits after a successful subtract.
    assign w_dshift = {r_rem, r_acc[WIDTH-1]};
    assign w_dfit   = (w_dshift >= {1'b0, r_b});
    assign w_ddiff  = w_dshift[WIDTH-1:0] - r_b;

    // Sign stage: re-apply signs; remainder follows the dividend.
    md_sign_fix #(.DATA_W(2*WIDTH)) u_fix_prod (
        .i_mag (r_acc),
        .i_neg (r_sa ^ r_sb),
        .o_res (w_prod)
    );

    md_sign_fix #(.DATA_W(WIDTH)) u_fix_quo (
        .i_mag (r_acc[WIDTH-1:0]),
        .i_neg (r_sa ^ r_sb),
        .o_res (w_quo)
    );

    md_sign_fix #(.DATA_W(WIDTH)) u_fix_rem (
        .i_mag (r_rem),
        .i_neg (r_sa),
        .o_res (w_rem)
    );

    md_sign_fix #(.DATA_W(WIDTH)) u_fix_dvd (
        .i_mag (r_a),
        .i_neg (r_sa),
        .o_res (w_dvd)
    );

    assign w_dz = (r_b == '0);

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (w_is_div) begin
            if (w_dz) begin
                w_res_hi = w_dvd;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quo;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_CALC;
            ST_CALC: if (w_last) w_state_nxt = ST_SIGN;
            ST_SIGN: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == ST_SIGN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op  <= MD_MULT;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_rem <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_op  <= w_op_in;
                        r_sa  <= w_sa_in;
                        r_sb  <= w_sb_in;
                        r_a   <= w_abs_a;
                        r_b   <= w_abs_b;
                        r_cnt <= '0;
                        r_rem <= '0;
                        r_acc <= md_is_div(w_op_in) ? {{WIDTH{1'b0}}, w_abs_a} : '0;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_is_div) begin
                        r_rem              <= w_dfit ? w_ddiff : w_dshift[WIDTH-1:0];
                        r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_dfit};
                    end else begin
                        r_acc <= {w_msum, r_acc[WIDTH-1:1]};
                        r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    end
                end
                ST_SIGN: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: reset, signed/unsigned mult/div, divide by
// zero, overflow, MTHI, ignored start/writes while busy, back-to-back and abort.
module tb_muldiv_unit;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; launches at the next posedge (E0) and returns at
    // the negedge of the done cycle, so consecutive calls start back-to-back.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input bit disturb, input string tag);
        int n;
        int busy_n;
        bit seen;
        bit stable;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; rs_data = ~a; rt_data = ~b;
        prev_hi = hi; prev_lo = lo;
        n = 0; busy_n = 0; seen = 1'b0; stable = 1'b1;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if (done) seen = 1'b1;
            if (!seen && (hi !== prev_hi || lo !== prev_lo)) stable = 1'b0;
            if (disturb && n == 10) begin
                start = 1'b1; op = MD_DIVU; rs_data = 32'd77; rt_data = 32'd3;
                hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
            end else begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
        end
        check({tag, "_latency"}, 64'(n), 64'd34);
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
        check({tag, "_hilo_stable"}, 64'(stable), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int done_n;
        rst_n = 1'b0; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);

        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
        run_op(MD_MULT,  32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "mult_neg1");
        run_op(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_min_sq");
        run_op(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2");
        run_op(MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "divu_100_7");
        run_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_ovf");
        run_op(MD_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b0, "divu_by0");
        run_op(MD_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0, "div_by0");

        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hAAAA5555;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check("mthi_hi", 64'(hi), 64'hAAAA5555);
        check("mthi_lo_kept", 64'(lo), 64'hFFFFFFFF);
        @(negedge clk);

        run_op(MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1, "multu_disturbed");
        @(negedge clk);
        check("ignored_start_idle", 64'(busy), 64'd0);

        op = MD_DIV; rs_data = 32'd1000; rt_data = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        done_n = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_n++;
        end
        check("abort_no_done", 64'(done_n), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the multi-cycle CPU. It sits directly downstream of the register file.
- Consumes the two register read operands (rs, rt) and holds the architectural HI/LO registers.
- MFHI/MFLO results return to the register-file write port through the existing writeback mux.
- Handles MULT, MULTU, DIV, DIVU, MTHI and MTLO. The controller stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk
- start  in  1  launch an operation; sampled only in IDLE
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- rs_data  in  WIDTH  operand A (multiplicand/dividend), register-file read port 1
- rt_data  in  WIDTH  operand B (multiplier/divisor), register-file read port 2
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data (rs_data routed by controller)
- busy  out  1  operation in progress
- done  out  1  single-cycle completion pulse
- hi  out  WIDTH  HI register (product high / remainder)
- lo  out  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; hi=0, lo=0, busy=0, done=0; counter and working registers cleared.
  - Reset during CALC or SIGN aborts the operation; no HI/LO update follows.
- States: IDLE, CALC, SIGN.
- IDLE:
  - Edge with start=1: latch op; for signed ops latch |rs_data| and |rt_data| plus the two sign bits. Clear the accumulator, set counter=0, go to CALC.
- CALC:
  - One iteration per cycle for exactly WIDTH cycles, then go to SIGN.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first. Unsigned 2*WIDTH-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, MSB first. Unsigned WIDTH+1-bit partial remainder.
- SIGN (1 cycle):
  - MULT: negate the 64-bit product if the sign bits differ.
  - DIV: negate the quotient if the sign bits differ; the remainder takes the dividend's sign.
  - Write hi/lo at the SIGN->IDLE edge and assert done for exactly one cycle.
- Timing (start sampled at edge E0):
  - busy=1 for the cycles following E0 through E33, i.e. 33 cycles.
  - hi/lo updated and done=1 in the cycle following E33, with busy=0 in that same cycle.
  - A back-to-back start is accepted in that done cycle.
- Divide by zero (rt_data=0, either signedness):
  - Completes with normal latency; forced result hi=rs_data, lo=all-ones.
- Signed overflow 0x80000000 / 0xFFFFFFFF:
  - lo=0x80000000, hi=0 (magnitude arithmetic wraps naturally; no trap).
- start while busy: ignored; the in-flight operation is unaffected.
- hi_we/lo_we:
  - In IDLE: write wdata to hi/lo at the next edge; hi_we and lo_we together write both.
  - While busy: ignored; the controller guarantees a stall.
  - Same IDLE cycle as start: the write lands at E0, then is overwritten by the result at completion.
- hi/lo are stable during busy and hold the previous result until done.
- op and operands are sampled only at E0; later changes have no effect.

Decomposition:
- Shared package (cpu_defs): op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU, the state encoding, and the WIDTH default.
- One natural sub-module: md_sign_fix, combinational (magnitude in / sign bits in -> signed result out), used both at entry (abs) and in SIGN (negate).
- Counter, datapath and FSM stay in muldiv_unit.

Test Plan:
- Reset: after reset, hi=0, lo=0, busy=0, done=0. Then MULTU 0xFFFFFFFF*0xFFFFFFFF -> done 34 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high exactly 33 cycles.
- MULT: -1*1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV: -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Divide by zero: DIVU 0x1234/0 and DIV 0xFFFFFFF0/0 -> hi=rs_data, lo=0xFFFFFFFF, normal latency.
- Collisions: MTHI 0xAAAA5555 in IDLE -> hi updated next edge. Start pulsed mid-operation -> ignored. hi_we mid-operation -> hi unchanged until done. Back-to-back start in the done cycle -> second result 34 cycles later.
- Abort: rst_n=0 at cycle 10 of a DIV -> hi=lo=0, busy=0, no done pulse afterwards.
